// File: rtl/tia_hsync_sequencer.sv
// TIA horizontal timing: two-phase clock divider, 57-count line counter and per-line event decode.
// Optional macro TIA_HSEQ_WSYNC_EN builds the WSYNC/rdy logic; otherwise rdy is tied high.
module tia_hsync_sequencer (
    input  logic       clk,
    input  logic       r,
    input  logic       rsync,
    input  logic       hmove,
    input  logic       wsync,
    output logic       hphi1,
    output logic       hphi2,
    output logic [5:0] hpos,
    output logic       hsync,
    output logic       hblank,
    output logic       center,
    output logic       line_end,
    output logic       rdy
);

    logic [1:0] r_ph;
    logic [5:0] r_hpos;
    logic       r_hsync;
    logic       r_hblank;
    logic       r_hm_latch;
    logic       r_hm_ext;

    logic       w_adv;
    logic [5:0] w_hpos_next;

    // Counter advances once per phase cycle; RSYNC pre-empts every normal update.
    assign w_adv       = (r_ph == 2'd3) && !rsync;
    assign w_hpos_next = (r_hpos >= 6'd56) ? 6'd0 : r_hpos + 6'd1;

    always_ff @(posedge clk) begin
        if (r) begin
            r_ph       <= 2'd0;
            r_hpos     <= 6'd0;
            r_hsync    <= 1'b0;
            r_hblank   <= 1'b1;
            r_hm_latch <= 1'b0;
            r_hm_ext   <= 1'b0;
        end else begin
            r_ph <= rsync ? 2'd0 : r_ph + 2'd1;

            if (rsync) begin
                r_hpos   <= 6'd0;
                r_hblank <= 1'b1;
                r_hsync  <= 1'b0;
            end else if (w_adv) begin
                r_hpos <= w_hpos_next;
                case (w_hpos_next)
                    6'd0:  r_hblank <= 1'b1;
                    6'd4:  r_hsync  <= 1'b1;
                    6'd8:  r_hsync  <= 1'b0;
                    6'd16: if (!r_hm_latch) r_hblank <= 1'b0;
                    6'd18: if (r_hm_ext) r_hblank <= 1'b0;
                    default: ;
                endcase
            end

            // The latch is only looked at on entry to 16; r_hm_ext remembers that decision until 18.
            if (w_adv && (w_hpos_next == 6'd16)) begin
                r_hm_ext <= r_hm_latch;
            end

            if (hmove) begin
                r_hm_latch <= 1'b1;
            end else if (w_adv && (w_hpos_next == 6'd18) && r_hm_ext) begin
                r_hm_latch <= 1'b0;
            end
        end
    end

`ifdef TIA_HSEQ_WSYNC_EN
    logic r_rdy;
    logic w_enter0;

    assign w_enter0 = rsync || (w_adv && (w_hpos_next == 6'd0));

    // A strobe on the line-start edge wins, so the CPU waits out the whole next line.
    always_ff @(posedge clk) begin
        if (r) begin
            r_rdy <= 1'b1;
        end else if (wsync) begin
            r_rdy <= 1'b0;
        end else if (w_enter0) begin
            r_rdy <= 1'b1;
        end
    end

    assign rdy = r_rdy;
`else
    logic w_unused_wsync;

    assign w_unused_wsync = wsync;
    assign rdy            = 1'b1;
`endif

    assign hphi1    = (r_ph == 2'd1);
    assign hphi2    = (r_ph == 2'd3);
    assign hpos     = r_hpos;
    assign hsync    = r_hsync;
    assign hblank   = r_hblank;
    assign center   = (r_hpos == 6'd36) && (r_ph == 2'd0);
    assign line_end = (r_hpos == 6'd56) && (r_ph == 2'd3);

endmodule

// File: tb/tb_tia_hsync_sequencer.sv
// Directed bench for tia_hsync_sequencer: free-run vector table plus HMOVE/WSYNC/RSYNC/reset sequences.
module tb_tia_hsync_sequencer;

    logic       clk = 1'b0;
    logic       r = 1'b1;
    logic       rsync = 1'b0;
    logic       hmove = 1'b0;
    logic       wsync = 1'b0;
    logic       hphi1, hphi2, hsync, hblank, center, line_end, rdy;
    logic [5:0] hpos;

    tia_hsync_sequencer dut (
        .clk      (clk),
        .r        (r),
        .rsync    (rsync),
        .hmove    (hmove),
        .wsync    (wsync),
        .hphi1    (hphi1),
        .hphi2    (hphi2),
        .hpos     (hpos),
        .hsync    (hsync),
        .hblank   (hblank),
        .center   (center),
        .line_end (line_end),
        .rdy      (rdy)
    );

    always #5 clk = ~clk;

`ifdef TIA_HSEQ_WSYNC_EN
    localparam int RDY_LOW = 0;
`else
    localparam int RDY_LOW = 1;
`endif

    typedef struct {
        int at;
        bit i_rsync, i_hmove, i_wsync;
        int hpos;
        bit phi1, phi2, hsync, hblank, center, le, rdy;
    } vec_t;

    localparam int NV = 19;
    vec_t tbl [NV];

    int cyc;
    int nvec;
    int nfail;
    int hs_cnt;
    int le_cnt;

    task automatic chk(input string nm, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s @clk %0d: got %0d, expected %0d", nm, cyc, act, exp);
        end
    endtask

    task automatic chk_vec(input vec_t v);
        chk("tbl_hpos", int'(hpos), v.hpos);
        chk("tbl_hphi1", int'(hphi1), int'(v.phi1));
        chk("tbl_hphi2", int'(hphi2), int'(v.phi2));
        chk("tbl_hsync", int'(hsync), int'(v.hsync));
        chk("tbl_hblank", int'(hblank), int'(v.hblank));
        chk("tbl_center", int'(center), int'(v.center));
        chk("tbl_line_end", int'(line_end), int'(v.le));
        chk("tbl_rdy", int'(rdy), int'(v.rdy));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int k);
        while (cyc < k) tick();
    endtask

    // After this the bench sits in clk 1: the first period whose closing edge samples r low.
    task automatic do_reset();
        r = 1'b1;
        rsync = 1'b0;
        hmove = 1'b0;
        wsync = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        r = 1'b0;
        cyc = 1;
    endtask

    task automatic strobe(input bit s_rs, input bit s_hm, input bit s_ws);
        rsync = s_rs;
        hmove = s_hm;
        wsync = s_ws;
        tick();
        rsync = 1'b0;
        hmove = 1'b0;
        wsync = 1'b0;
    endtask

    initial begin
        nvec = 0;
        nfail = 0;

        //           at  rs hm ws hpos p1 p2 hs hb ce le rdy
        tbl[0]  = '{  1, 0, 0, 0,  0,  0, 0, 0, 1, 0, 0, 1};
        tbl[1]  = '{  2, 0, 0, 0,  0,  1, 0, 0, 1, 0, 0, 1};
        tbl[2]  = '{  4, 0, 0, 0,  0,  0, 1, 0, 1, 0, 0, 1};
        tbl[3]  = '{  5, 0, 0, 0,  1,  0, 0, 0, 1, 0, 0, 1};
        tbl[4]  = '{ 16, 0, 0, 0,  3,  0, 1, 0, 1, 0, 0, 1};
        tbl[5]  = '{ 17, 0, 0, 0,  4,  0, 0, 1, 1, 0, 0, 1};
        tbl[6]  = '{ 32, 0, 0, 0,  7,  0, 1, 1, 1, 0, 0, 1};
        tbl[7]  = '{ 33, 0, 0, 0,  8,  0, 0, 0, 1, 0, 0, 1};
        tbl[8]  = '{ 64, 0, 0, 0, 15,  0, 1, 0, 1, 0, 0, 1};
        tbl[9]  = '{ 65, 0, 0, 0, 16,  0, 0, 0, 0, 0, 0, 1};
        tbl[10] = '{144, 0, 0, 0, 35,  0, 1, 0, 0, 0, 0, 1};
        tbl[11] = '{145, 0, 0, 0, 36,  0, 0, 0, 0, 1, 0, 1};
        tbl[12] = '{146, 0, 0, 0, 36,  1, 0, 0, 0, 0, 0, 1};
        tbl[13] = '{228, 0, 0, 0, 56,  0, 1, 0, 0, 0, 1, 1};
        tbl[14] = '{229, 0, 0, 0,  0,  0, 0, 0, 1, 0, 0, 1};
        tbl[15] = '{245, 0, 0, 0,  4,  0, 0, 1, 1, 0, 0, 1};
        tbl[16] = '{293, 0, 0, 0, 16,  0, 0, 0, 0, 0, 0, 1};
        tbl[17] = '{456, 0, 0, 0, 56,  0, 1, 0, 0, 0, 1, 1};
        tbl[18] = '{457, 0, 0, 0,  0,  0, 0, 0, 1, 0, 0, 1};

        // Free run over two lines, table checkpoints plus per-clock counter/phase model.
        do_reset();
        hs_cnt = 0;
        le_cnt = 0;
        for (int k = 1; k <= 457; k++) begin
            run_to(k);
            rsync = 1'b0;
            hmove = 1'b0;
            wsync = 1'b0;
            for (int i = 0; i < NV; i++) begin
                if (tbl[i].at == k) begin
                    chk_vec(tbl[i]);
                    rsync = tbl[i].i_rsync;
                    hmove = tbl[i].i_hmove;
                    wsync = tbl[i].i_wsync;
                end
            end
            chk("hpos_walk", int'(hpos), ((k - 1) / 4) % 57);
            chk("hphi1_walk", int'(hphi1), int'(((k - 1) % 4) == 1));
            chk("phi_overlap", int'(hphi1 & hphi2), 0);
            if (k <= 228 && hsync) hs_cnt++;
            if (line_end) le_cnt++;
        end
        chk("hsync_width", hs_cnt, 16);
        chk("line_end_count", le_cnt, 2);

        // HMOVE early in the line extends blank to 18; next line is normal.
        do_reset();
        run_to(10);
        strobe(0, 1, 0);
        run_to(64);  chk("hm_a_blank64", int'(hblank), 1);
        run_to(65);  chk("hm_a_blank65", int'(hblank), 1);
        run_to(72);  chk("hm_a_blank72", int'(hblank), 1);
        run_to(73);  chk("hm_a_blank73", int'(hblank), 0);
        run_to(292); chk("hm_a_blank292", int'(hblank), 1);
        run_to(293); chk("hm_a_blank293", int'(hblank), 0);

        // Strobe on the clearing edge keeps the latch, so the next line extends too.
        do_reset();
        run_to(10);
        strobe(0, 1, 0);
        run_to(72);  chk("hm_b_blank72", int'(hblank), 1);
        strobe(0, 1, 0);
        chk("hm_b_blank73", int'(hblank), 0);
        run_to(293); chk("hm_b_blank293", int'(hblank), 1);
        run_to(300); chk("hm_b_blank300", int'(hblank), 1);
        run_to(301); chk("hm_b_blank301", int'(hblank), 0);

        // Late strobe carries into the following line only.
        do_reset();
        run_to(100);
        strobe(0, 1, 0);
        run_to(293); chk("hm_c_blank293", int'(hblank), 1);
        run_to(301); chk("hm_c_blank301", int'(hblank), 0);
        run_to(521); chk("hm_c_blank521", int'(hblank), 0);

        // WSYNC hold, repeat strobe ignored, strobe on line-start edge holds a full line.
        do_reset();
        run_to(100); chk("ws_rdy100", int'(rdy), 1);
        strobe(0, 0, 1);
        chk("ws_rdy101", int'(rdy), RDY_LOW);
        run_to(150);
        strobe(0, 0, 1);
        run_to(228); chk("ws_rdy228", int'(rdy), RDY_LOW);
        run_to(229); chk("ws_rdy229", int'(rdy), 1);
        run_to(456);
        strobe(0, 0, 1);
        chk("ws_rdy457", int'(rdy), RDY_LOW);
        run_to(684); chk("ws_rdy684", int'(rdy), RDY_LOW);
        run_to(685); chk("ws_rdy685", int'(rdy), 1);

        // RSYNC mid-line releases WSYNC and restarts timing; then RSYNC on a natural wrap.
        do_reset();
        run_to(110);
        strobe(0, 0, 1);
        run_to(120);
        chk("rs_hpos120", int'(hpos), 29);
        chk("rs_rdy120", int'(rdy), RDY_LOW);
        chk("rs_blank120", int'(hblank), 0);
        strobe(1, 0, 0);
        chk("rs_hpos121", int'(hpos), 0);
        chk("rs_blank121", int'(hblank), 1);
        chk("rs_hsync121", int'(hsync), 0);
        chk("rs_phi1_121", int'(hphi1), 0);
        chk("rs_phi2_121", int'(hphi2), 0);
        chk("rs_rdy121", int'(rdy), 1);
        run_to(122); chk("rs_phi1_122", int'(hphi1), 1);
        run_to(136); chk("rs_hsync136", int'(hsync), 0);
        run_to(137);
        chk("rs_hsync137", int'(hsync), 1);
        chk("rs_hpos137", int'(hpos), 4);
        run_to(348);
        chk("rs_hpos348", int'(hpos), 56);
        chk("rs_le348", int'(line_end), 1);
        strobe(1, 0, 0);
        chk("rs_wrap_hpos", int'(hpos), 0);
        chk("rs_wrap_blank", int'(hblank), 1);
        chk("rs_wrap_phi1", int'(hphi1), 0);
        run_to(353); chk("rs_wrap_hpos353", int'(hpos), 1);

        // RSYNC during HSYNC drops it at once.
        do_reset();
        run_to(20);
        chk("rs_f_hsync20", int'(hsync), 1);
        strobe(1, 0, 0);
        chk("rs_f_hsync21", int'(hsync), 0);
        chk("rs_f_hpos21", int'(hpos), 0);
        chk("rs_f_blank21", int'(hblank), 1);

        // Reset mid-line with latch set and WSYNC pending; reset beats simultaneous strobes.
        do_reset();
        run_to(100);
        strobe(0, 1, 0);
        run_to(150);
        strobe(0, 0, 1);
        run_to(162);
        chk("rst_hpos162", int'(hpos), 40);
        chk("rst_rdy162", int'(rdy), RDY_LOW);
        r = 1'b1;
        rsync = 1'b1;
        hmove = 1'b1;
        wsync = 1'b1;
        tick();
        r = 1'b0;
        rsync = 1'b0;
        hmove = 1'b0;
        wsync = 1'b0;
        cyc = 1;
        chk("rst_hpos", int'(hpos), 0);
        chk("rst_hphi1", int'(hphi1), 0);
        chk("rst_hphi2", int'(hphi2), 0);
        chk("rst_hsync", int'(hsync), 0);
        chk("rst_hblank", int'(hblank), 1);
        chk("rst_center", int'(center), 0);
        chk("rst_line_end", int'(line_end), 0);
        chk("rst_rdy", int'(rdy), 1);
        run_to(64); chk("rst_blank64", int'(hblank), 1);
        run_to(65); chk("rst_blank65", int'(hblank), 0);
        run_to(73); chk("rst_blank73", int'(hblank), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
